// File: rtl/hcube_mm_ctrl.sv
// Control sequencer for hypercube matrix multiply on 2^DIM nodes:
// chunked load, A/B broadcast, local multiply, optional C reduction.
module hcube_mm_ctrl #(
   parameter  int DIM       = 3,
   parameter  int LOAD_W    = 4,
   parameter  int BA_STEPS  = 1,
   parameter  int BB_STEPS  = 1,
   parameter  int RED_STEPS = 0,
   localparam int P         = 1 << DIM,
   localparam int DW        = (DIM > 1) ? $clog2(DIM) : 1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          STM,
   input  logic          ABORT,
   output logic [P-1:0]  ENa,
   output logic [P-1:0]  ENb,
   output logic [P-1:0]  ENc,
   output logic [P-1:0]  SEL,
   output logic [DW-1:0] DSEL,
   output logic [2:0]    PHASE,
   output logic          BUSY,
   output logic          EOM,
   output logic          DONE
);

   localparam int L    = P / LOAD_W;
   localparam int SMAX = (L > DIM) ? L : DIM;
   localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;

   localparam logic [SW-1:0] L_LAST   = SW'(L - 1);
   localparam logic [SW-1:0] BA_LAST  = SW'((BA_STEPS > 0) ? BA_STEPS - 1 : 0);
   localparam logic [SW-1:0] BB_LAST  = SW'((BB_STEPS > 0) ? BB_STEPS - 1 : 0);
   localparam logic [SW-1:0] RED_LAST = SW'((RED_STEPS > 0) ? RED_STEPS - 1 : 0);

   generate
      if (DIM < 1 || DIM > 6) begin : g_bad_dim
         $error("hcube_mm_ctrl: DIM out of range");
      end
      if (LOAD_W < 1 || LOAD_W > P || (LOAD_W & (LOAD_W - 1)) != 0) begin : g_bad_lw
         $error("hcube_mm_ctrl: LOAD_W illegal");
      end
      if (BA_STEPS < 0 || BB_STEPS < 0 || BA_STEPS + BB_STEPS > DIM) begin : g_bad_bc
         $error("hcube_mm_ctrl: broadcast steps illegal");
      end
      if (RED_STEPS < 0 || RED_STEPS > DIM) begin : g_bad_red
         $error("hcube_mm_ctrl: RED_STEPS illegal");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_BCA  = 3'd2,
      S_BCB  = 3'd3,
      S_MUL  = 3'd4,
      S_RED  = 3'd5,
      S_FIN  = 3'd6
   } state_t;

   // Zero-length phases are bypassed at elaboration time.
   localparam state_t AFTER_LOAD = (BA_STEPS > 0) ? S_BCA :
                                   (BB_STEPS > 0) ? S_BCB : S_MUL;
   localparam state_t AFTER_BCA  = (BB_STEPS > 0) ? S_BCB : S_MUL;
   localparam state_t AFTER_MUL  = (RED_STEPS > 0) ? S_RED : S_FIN;

   state_t        state;
   state_t        next;
   logic [SW-1:0] s;
   logic [SW-1:0] s_next;

   function automatic logic [P-1:0] dim_mask(input int d, input logic one);
      logic [P-1:0] m;
      m = '0;
      for (int n = 0; n < P; n++) begin
         m[n] = ((((n >> d) & 1) == 1) == one);
      end
      return m;
   endfunction

   function automatic logic [P-1:0] load_mask(input int c);
      logic [P-1:0] m;
      m = '0;
      for (int n = 0; n < P; n++) begin
         m[n] = ((n / LOAD_W) == c);
      end
      return m;
   endfunction

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= S_IDLE;
         s     <= '0;
      end else begin
         state <= next;
         s     <= s_next;
      end
   end

   always_comb begin
      next = S_IDLE;
      case (state)
         S_IDLE: next = STM ? S_LOAD : S_IDLE;
         S_LOAD: next = (s == L_LAST) ? AFTER_LOAD : S_LOAD;
         S_BCA:  next = (s == BA_LAST) ? AFTER_BCA : S_BCA;
         S_BCB:  next = (s == BB_LAST) ? S_MUL : S_BCB;
         S_MUL:  next = AFTER_MUL;
         S_RED:  next = (s == RED_LAST) ? S_FIN : S_RED;
         S_FIN:  next = STM ? S_LOAD : S_IDLE;
         default: next = S_IDLE;
      endcase
      if (ABORT) begin
         next = S_IDLE;
      end
      s_next = '0;
      if (next == state && state != S_IDLE) begin
         s_next = s + 1'b1;
      end
   end

   always_comb begin
      int d;
      d     = 0;
      ENa   = '0;
      ENb   = '0;
      ENc   = '0;
      SEL   = '0;
      DSEL  = '0;
      PHASE = 3'd0;
      BUSY  = 1'b1;
      EOM   = 1'b0;
      DONE  = 1'b0;
      case (state)
         S_IDLE: begin
            BUSY = 1'b0;
            EOM  = 1'b1;
         end
         S_LOAD: begin
            PHASE = 3'd1;
            ENa   = load_mask(int'(s));
            ENb   = load_mask(int'(s));
         end
         S_BCA: begin
            PHASE = 3'd2;
            d     = int'(s);
            ENa   = dim_mask(d, 1'b1);
            SEL   = dim_mask(d, 1'b1);
            DSEL  = DW'(d);
         end
         S_BCB: begin
            PHASE = 3'd3;
            d     = BA_STEPS + int'(s);
            ENb   = dim_mask(d, 1'b0);
            SEL   = dim_mask(d, 1'b0);
            DSEL  = DW'(d);
         end
         S_MUL: begin
            PHASE = 3'd4;
            ENc   = '1;
         end
         // Lower-half nodes of the active dimension accumulate partner C.
         S_RED: begin
            PHASE = 3'd5;
            d     = DIM - 1 - int'(s);
            ENc   = dim_mask(d, 1'b0);
            SEL   = dim_mask(d, 1'b0);
            DSEL  = DW'(d);
         end
         S_FIN: begin
            PHASE = 3'd6;
            DONE  = 1'b1;
         end
         default: begin
            BUSY = 1'b0;
            EOM  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_hcube_mm_ctrl.sv
// Bench for hcube_mm_ctrl: three configurations share stimulus and are
// checked every cycle against a run-position model plus fixed values.
module tb_hcube_mm_ctrl;

   logic clk = 1'b0;
   logic rst;
   logic stm;
   logic abort;
   bit   chk_en;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   localparam int M_DIM[3] = '{3, 3, 4};
   localparam int M_LW[3]  = '{4, 4, 16};
   localparam int M_BA[3]  = '{1, 1, 2};
   localparam int M_BB[3]  = '{1, 1, 2};
   localparam int M_RED[3] = '{0, 2, 0};

   logic [7:0]  ena0, enb0, enc0, sel0;
   logic [1:0]  dsel0;
   logic [2:0]  ph0;
   logic        busy0, eom0, done0;
   logic [7:0]  ena1, enb1, enc1, sel1;
   logic [1:0]  dsel1;
   logic [2:0]  ph1;
   logic        busy1, eom1, done1;
   logic [15:0] ena2, enb2, enc2, sel2;
   logic [1:0]  dsel2;
   logic [2:0]  ph2;
   logic        busy2, eom2, done2;

   hcube_mm_ctrl #(.DIM(3), .LOAD_W(4), .BA_STEPS(1), .BB_STEPS(1),
                   .RED_STEPS(0)) u0 (
      .CLK(clk), .RST(rst), .STM(stm), .ABORT(abort),
      .ENa(ena0), .ENb(enb0), .ENc(enc0), .SEL(sel0), .DSEL(dsel0),
      .PHASE(ph0), .BUSY(busy0), .EOM(eom0), .DONE(done0)
   );

   hcube_mm_ctrl #(.DIM(3), .LOAD_W(4), .BA_STEPS(1), .BB_STEPS(1),
                   .RED_STEPS(2)) u1 (
      .CLK(clk), .RST(rst), .STM(stm), .ABORT(abort),
      .ENa(ena1), .ENb(enb1), .ENc(enc1), .SEL(sel1), .DSEL(dsel1),
      .PHASE(ph1), .BUSY(busy1), .EOM(eom1), .DONE(done1)
   );

   hcube_mm_ctrl #(.DIM(4), .LOAD_W(16), .BA_STEPS(2), .BB_STEPS(2),
                   .RED_STEPS(0)) u2 (
      .CLK(clk), .RST(rst), .STM(stm), .ABORT(abort),
      .ENa(ena2), .ENb(enb2), .ENc(enc2), .SEL(sel2), .DSEL(dsel2),
      .PHASE(ph2), .BUSY(busy2), .EOM(eom2), .DONE(done2)
   );

   // Model: each DUT is either idle or at position pos within its run.
   bit act[3];
   int pos[3];

   function automatic int run_len(input int u);
      return ((1 << M_DIM[u]) / M_LW[u]) + M_BA[u] + M_BB[u] + M_RED[u] + 2;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int u = 0; u < 3; u++) begin
         if (rst) begin
            act[u] <= 1'b0;
            pos[u] <= 0;
         end else if (!act[u]) begin
            if (stm && !abort) begin
               act[u] <= 1'b1;
               pos[u] <= 0;
            end
         end else if (abort) begin
            act[u] <= 1'b0;
            pos[u] <= 0;
         end else if (pos[u] == run_len(u) - 1) begin
            if (stm) pos[u] <= 0;
            else act[u] <= 1'b0;
         end else begin
            pos[u] <= pos[u] + 1;
         end
      end
   end

   function automatic void model_out(
      input int u, input bit a, input int k,
      output logic [15:0] ea, output logic [15:0] eb,
      output logic [15:0] ec, output logic [15:0] es,
      output int ds, output int ph,
      output logic bz, output logic eo, output logic dn);
      int p, l, kk;
      ea = '0; eb = '0; ec = '0; es = '0;
      ds = 0; ph = 0; bz = 1'b0; eo = 1'b1; dn = 1'b0;
      if (!a) return;
      p  = 1 << M_DIM[u];
      l  = p / M_LW[u];
      bz = 1'b1;
      eo = 1'b0;
      kk = k;
      if (kk < l) begin
         ph = 1;
         for (int n = kk * M_LW[u]; n < (kk + 1) * M_LW[u]; n++) ea[n] = 1'b1;
         eb = ea;
         return;
      end
      kk -= l;
      if (kk < M_BA[u]) begin
         ph = 2;
         ds = kk;
         for (int n = 0; n < p; n++) ea[n] = ((n >> ds) % 2) == 1;
         es = ea;
         return;
      end
      kk -= M_BA[u];
      if (kk < M_BB[u]) begin
         ph = 3;
         ds = M_BA[u] + kk;
         for (int n = 0; n < p; n++) eb[n] = ((n >> ds) % 2) == 0;
         es = eb;
         return;
      end
      kk -= M_BB[u];
      if (kk == 0) begin
         ph = 4;
         for (int n = 0; n < p; n++) ec[n] = 1'b1;
         return;
      end
      kk -= 1;
      if (kk < M_RED[u]) begin
         ph = 5;
         ds = M_DIM[u] - 1 - kk;
         for (int n = 0; n < p; n++) ec[n] = ((n >> ds) % 2) == 0;
         es = ec;
         return;
      end
      ph = 6;
      dn = 1'b1;
   endfunction

   task automatic cmp(input int u,
                      input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] s,
                      input int ds, input int ph,
                      input logic bz, input logic eo, input logic dn);
      logic [15:0] ea, eb, ec, es;
      int eds, eph;
      logic ebz, eeo, edn;
      model_out(u, act[u], pos[u], ea, eb, ec, es, eds, eph, ebz, eeo, edn);
      vectors++;
      if (a !== ea || b !== eb || c !== ec || s !== es || ds != eds ||
          ph != eph || bz !== ebz || eo !== eeo || dn !== edn) begin
         miscompares++;
         $display("FAIL dut%0d t=%0t got ena=%h enb=%h enc=%h sel=%h dsel=%0d ph=%0d busy=%b eom=%b done=%b want ena=%h enb=%h enc=%h sel=%h dsel=%0d ph=%0d busy=%b eom=%b done=%b",
                  u, $time, a, b, c, s, ds, ph, bz, eo, dn,
                  ea, eb, ec, es, eds, eph, ebz, eeo, edn);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(0, 16'(ena0), 16'(enb0), 16'(enc0), 16'(sel0), int'(dsel0),
             int'(ph0), busy0, eom0, done0);
         cmp(1, 16'(ena1), 16'(enb1), 16'(enc1), 16'(sel1), int'(dsel1),
             int'(ph1), busy1, eom1, done1);
         cmp(2, ena2, enb2, enc2, sel2, int'(dsel2),
             int'(ph2), busy2, eom2, done2);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got %h want %h", nm, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int b0, b1, b2, dn;
      rst    = 1'b1;
      stm    = 1'b0;
      abort  = 1'b0;
      chk_en = 1'b0;
      repeat (3) tick();
      chk("rst_phase", 32'(ph0), 32'd0);
      chk("rst_eom", 32'(eom0), 32'd1);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_en", {8'(ena0), 8'(enb0), 8'(enc0), 8'(sel0)}, 32'd0);
      chk("rst_done_dsel", {29'd0, done0, dsel0}, 32'd0);
      rst    = 1'b0;
      chk_en = 1'b1;
      tick();

      // Single run from a one-cycle start pulse.
      b0 = 0; b1 = 0; b2 = 0;
      stm = 1'b1;
      tick();
      stm = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         b0 += int'(busy0);
         b1 += int'(busy1);
         b2 += int'(busy2);
         case (i)
            1: begin
               chk("load0_ena", 32'(ena0), 32'h0F);
               chk("load0_enb", 32'(enb0), 32'h0F);
               chk("w16_load_ena", 32'(ena2), 32'hFFFF);
               chk("w16_load_enb", 32'(enb2), 32'hFFFF);
            end
            2: begin
               chk("load1_ena", 32'(ena0), 32'hF0);
               chk("load1_enb", 32'(enb0), 32'hF0);
               chk("w16_bca0_ena", 32'(ena2), 32'hAAAA);
            end
            3: begin
               chk("bca_ena", 32'(ena0), 32'hAA);
               chk("bca_sel", 32'(sel0), 32'hAA);
               chk("bca_dsel", 32'(dsel0), 32'd0);
               chk("w16_bca1_ena", 32'(ena2), 32'hCCCC);
               chk("w16_bca1_dsel", 32'(dsel2), 32'd1);
            end
            4: begin
               chk("bcb_enb", 32'(enb0), 32'h33);
               chk("bcb_sel", 32'(sel0), 32'h33);
               chk("bcb_dsel", 32'(dsel0), 32'd1);
               chk("w16_bcb0_enb", 32'(enb2), 32'h0F0F);
            end
            5: begin
               chk("mul_enc", 32'(enc0), 32'hFF);
               chk("mul_sel", 32'(sel0), 32'h00);
               chk("w16_bcb1_enb", 32'(enb2), 32'h00FF);
               chk("w16_bcb1_dsel", 32'(dsel2), 32'd3);
            end
            6: begin
               chk("fin_done", 32'(done0), 32'd1);
               chk("red0_enc", 32'(enc1), 32'h0F);
               chk("red0_sel", 32'(sel1), 32'h0F);
               chk("red0_dsel", 32'(dsel1), 32'd2);
               chk("w16_mul_enc", 32'(enc2), 32'hFFFF);
            end
            7: begin
               chk("idle_eom", 32'(eom0), 32'd1);
               chk("red1_enc", 32'(enc1), 32'h33);
               chk("red1_dsel", 32'(dsel1), 32'd1);
            end
            8: chk("red_fin_done", 32'(done1), 32'd1);
            default: ;
         endcase
         tick();
      end
      chk("busy_cycles_def", 32'(b0), 32'd6);
      chk("busy_cycles_red", 32'(b1), 32'd8);
      chk("busy_cycles_w16", 32'(b2), 32'd7);

      // Back-to-back runs with start held high.
      dn  = 0;
      stm = 1'b1;
      tick();
      for (int i = 1; i <= 12; i++) begin
         chk("b2b_eom", 32'(eom0), 32'd0);
         if (i == 7) chk("b2b_load0_ena", 32'(ena0), 32'h0F);
         dn += int'(done0);
         if (i == 12) stm = 1'b0;
         tick();
      end
      chk("b2b_done_pulses", 32'(dn), 32'd2);
      chk("b2b_end_eom", 32'(eom0), 32'd1);
      repeat (12) tick();

      // Abort during BCB.
      stm = 1'b1;
      tick();
      stm = 1'b0;
      repeat (3) tick();
      chk("abort_pre_phase", 32'(ph0), 32'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_phase", 32'(ph0), 32'd0);
      chk("abort_eom", 32'(eom0), 32'd1);
      chk("abort_en", {8'(ena0), 8'(enb0), 8'(enc0), 8'(sel0)}, 32'd0);
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         dn += int'(done0);
         tick();
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      stm = 1'b1;
      tick();
      stm = 1'b0;
      chk("post_abort_load0", 32'(ena0), 32'h0F);
      repeat (10) tick();

      // Asynchronous reset in the middle of LOAD1.
      stm = 1'b1;
      tick();
      stm = 1'b0;
      tick();
      chk("pre_rst_load1", 32'(ena0), 32'hF0);
      rst = 1'b1;
      stm = 1'b1;
      #1;
      chk("async_rst_en", {8'(ena0), 8'(enb0), 8'(enc0), 8'(sel0)}, 32'd0);
      chk("async_rst_phase", 32'(ph0), 32'd0);
      chk("async_rst_eom", 32'(eom0), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_hold_busy", 32'(busy0), 32'd0);
      end
      rst = 1'b0;
      stm = 1'b0;
      tick();
      chk("rst_release_phase", 32'(ph0), 32'd0);

      // Randomized start/abort/reset traffic.
      for (int i = 0; i < 3000; i++) begin
         stm   = ($urandom_range(0, 2) == 0);
         abort = ($urandom_range(0, 24) == 0);
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      stm   = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      repeat (20) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
